// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Decode-stage branch/JAL/JALR resolution and load-use hazard
//            detection. Redirects and flushes are produced in the same cycle
//            as the instruction. A load-use hazard stalls the instruction for
//            exactly one cycle through a two-state FSM (RUN / LDSTALL).
// Ports    : clk, rst            - clock, synchronous active-high reset
//            valid_s2, is_*_s2   - decode instruction valid and class
//            funct3_s2, rs*_s2   - branch condition and source registers
//            rd_s3, memread_s3   - execute-stage destination and load flag
//            BrEq, BrLT          - comparator results
//            hold_in             - global pipeline freeze
//            BrUn                - unsigned-compare select to the comparator
//            pc_sel              - 00 PC+4, 01 branch/JAL target, 10 JALR target
//            flush_s1, stall_s2, bubble_s3, illegal_br - pipeline control
//            stat_*              - statistics counters (STAT_W bits)
// Config   : BRANCH_STATS_EN - when defined, the statistics counters are
//            implemented (saturating); otherwise the stat ports read 0.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_s2,
  input  logic              is_branch_s2,
  input  logic              is_jal_s2,
  input  logic              is_jalr_s2,
  input  logic [2:0]        funct3_s2,
  input  logic [4:0]        rs1_s2,
  input  logic [4:0]        rs2_s2,
  input  logic [4:0]        rd_s3,
  input  logic              memread_s3,
  input  logic              BrEq,
  input  logic              BrLT,
  input  logic              hold_in,
  output logic              BrUn,
  output logic [1:0]        pc_sel,
  output logic              flush_s1,
  output logic              stall_s2,
  output logic              bubble_s3,
  output logic              illegal_br,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_stalls
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    LDSTALL = 1'b1
  } state_t;

  state_t r_state;

  logic w_hazard;
  logic w_stall;
  logic w_resolve;
  logic w_illegal_f3;
  logic w_taken;
  logic w_redirect_tgt;
  logic w_redirect_jalr;

  // funct3[1] separates the unsigned compares (BLTU/BGEU) from the signed ones.
  assign BrUn = funct3_s2[1];

  // Only instructions that read rs1 (and rs2 for branches) through the
  // comparator/adder in decode can depend on the load; JAL reads nothing.
  assign w_hazard = memread_s3 && (rd_s3 != 5'd0) &&
                    (is_branch_s2 || is_jalr_s2) &&
                    ((rd_s3 == rs1_s2) || (is_branch_s2 && (rd_s3 == rs2_s2)));

  // Stall is state-derived and deliberately not masked by hold_in, so a frozen
  // pipeline keeps holding PC and IF/ID while the hazard is still pending.
  assign w_stall   = !rst && (r_state == RUN) && valid_s2 && w_hazard;
  assign w_resolve = !rst && !hold_in && valid_s2 && !w_stall;

  assign w_illegal_f3 = (funct3_s2[2:1] == 2'b01);

  always_comb begin
    w_taken = 1'b0;
    case (funct3_s2)
      3'b000:          w_taken = BrEq;
      3'b001:          w_taken = !BrEq;
      3'b100, 3'b110:  w_taken = BrLT;
      3'b101, 3'b111:  w_taken = !BrLT;
      default:         w_taken = 1'b0;
    endcase
  end

  assign w_redirect_tgt  = w_resolve && ((is_branch_s2 && w_taken) || is_jal_s2);
  assign w_redirect_jalr = w_resolve && is_jalr_s2;

  assign pc_sel     = w_redirect_jalr ? 2'b10 : (w_redirect_tgt ? 2'b01 : 2'b00);
  assign flush_s1   = w_redirect_tgt || w_redirect_jalr;
  assign stall_s2   = w_stall;
  assign bubble_s3  = w_stall && !hold_in;
  assign illegal_br = w_resolve && is_branch_s2 && w_illegal_f3;

  // LDSTALL always lasts one cycle: the stalled instruction is resolved on
  // the following cycle without re-checking the hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else if (!hold_in) begin
      case (r_state)
        RUN:     r_state <= w_stall ? LDSTALL : RUN;
        LDSTALL: r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] r_stat_branches;
  logic [STAT_W-1:0] r_stat_taken;
  logic [STAT_W-1:0] r_stat_stalls;

  localparam logic [STAT_W-1:0] C_STAT_MAX = {STAT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_branches <= '0;
      r_stat_taken    <= '0;
      r_stat_stalls   <= '0;
    end else if (!hold_in) begin
      if (w_resolve && (is_branch_s2 || is_jal_s2 || is_jalr_s2) &&
          (r_stat_branches != C_STAT_MAX))
        r_stat_branches <= r_stat_branches + 1'b1;
      if (flush_s1 && (r_stat_taken != C_STAT_MAX))
        r_stat_taken <= r_stat_taken + 1'b1;
      if (w_stall && (r_stat_stalls != C_STAT_MAX))
        r_stat_stalls <= r_stat_stalls + 1'b1;
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_taken    = r_stat_taken;
  assign stat_stalls   = r_stat_stalls;
`else
  assign stat_branches = '0;
  assign stat_taken    = '0;
  assign stat_stalls   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed self-checking bench for branch_resolve_unit. Inputs are
//            driven on the falling edge and outputs sampled 1 ns later, so the
//            following rising edge commits the state for the applied vector.
// Config   : BRANCH_STATS_EN - also exercises counter saturation (STAT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_s2, is_branch_s2, is_jal_s2, is_jalr_s2;
  logic [2:0]        funct3_s2;
  logic [4:0]        rs1_s2, rs2_s2, rd_s3;
  logic              memread_s3, BrEq, BrLT, hold_in;
  logic              BrUn;
  logic [1:0]        pc_sel;
  logic              flush_s1, stall_s2, bubble_s3, illegal_br;
  logic [STAT_W-1:0] stat_branches, stat_taken, stat_stalls;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .valid_s2(valid_s2),
    .is_branch_s2(is_branch_s2), .is_jal_s2(is_jal_s2), .is_jalr_s2(is_jalr_s2),
    .funct3_s2(funct3_s2), .rs1_s2(rs1_s2), .rs2_s2(rs2_s2),
    .rd_s3(rd_s3), .memread_s3(memread_s3), .BrEq(BrEq), .BrLT(BrLT),
    .hold_in(hold_in), .BrUn(BrUn), .pc_sel(pc_sel), .flush_s1(flush_s1),
    .stall_s2(stall_s2), .bubble_s3(bubble_s3), .illegal_br(illegal_br),
    .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_stalls(stat_stalls)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // cls: 0 none, 1 branch, 2 jal, 3 jalr
  task automatic drive(input logic v, input int cls, input logic [2:0] f3,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic mr,
                       input logic eq, input logic lt, input logic hd);
    @(negedge clk);
    valid_s2     = v;
    is_branch_s2 = (cls == 1);
    is_jal_s2    = (cls == 2);
    is_jalr_s2   = (cls == 3);
    funct3_s2    = f3;
    rs1_s2 = r1; rs2_s2 = r2; rd_s3 = rd;
    memread_s3 = mr; BrEq = eq; BrLT = lt; hold_in = hd;
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic [1:0] pc, input logic fl,
                           input logic st, input logic bu, input logic il);
    check({tag, ".pc_sel"},     {30'd0, pc_sel},     {30'd0, pc});
    check({tag, ".flush_s1"},   {31'd0, flush_s1},   {31'd0, fl});
    check({tag, ".stall_s2"},   {31'd0, stall_s2},   {31'd0, st});
    check({tag, ".bubble_s3"},  {31'd0, bubble_s3},  {31'd0, bu});
    check({tag, ".illegal_br"}, {31'd0, illegal_br}, {31'd0, il});
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 2, 3'b000, 5'd1, 5'd2, 5'd1, 1, 0, 0, 0);   // JAL under reset
    check_ctl("reset", 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    check("reset.stat_branches", {28'd0, stat_branches}, 32'd0);
    check("reset.stat_taken",    {28'd0, stat_taken},    32'd0);
    check("reset.stat_stalls",   {28'd0, stat_stalls},   32'd0);

    // BEQ taken
    drive(1, 1, 3'b000, 5'd1, 5'd2, 5'd9, 0, 1, 0, 0);
    check_ctl("beq", 2'b01, 1, 0, 0, 0);
    check("beq.BrUn", {31'd0, BrUn}, 32'd0);
    // BLTU not taken
    drive(1, 1, 3'b110, 5'd1, 5'd2, 5'd9, 0, 0, 0, 0);
    check_ctl("bltu", 2'b00, 0, 0, 0, 0);
    check("bltu.BrUn", {31'd0, BrUn}, 32'd1);
    // BLT taken, BGE taken, BGEU not taken
    drive(1, 1, 3'b100, 5'd1, 5'd2, 5'd9, 0, 0, 1, 0);
    check_ctl("blt", 2'b01, 1, 0, 0, 0);
    drive(1, 1, 3'b101, 5'd1, 5'd2, 5'd9, 0, 0, 0, 0);
    check_ctl("bge", 2'b01, 1, 0, 0, 0);
    drive(1, 1, 3'b111, 5'd1, 5'd2, 5'd9, 0, 0, 1, 0);
    check_ctl("bgeu", 2'b00, 0, 0, 0, 0);
    check("bgeu.BrUn", {31'd0, BrUn}, 32'd1);

    // BNE load-use on rs1: stall then resolve
    drive(1, 1, 3'b001, 5'd5, 5'd6, 5'd5, 1, 0, 0, 0);
    check_ctl("bne_stall", 2'b00, 0, 1, 1, 0);
    drive(1, 1, 3'b001, 5'd5, 5'd6, 5'd5, 1, 0, 0, 0);
    check_ctl("bne_resolve", 2'b01, 1, 0, 0, 0);
    // Hazard via rs2 on a branch
    drive(1, 1, 3'b000, 5'd3, 5'd7, 5'd7, 1, 0, 0, 0);
    check_ctl("rs2_stall", 2'b00, 0, 1, 1, 0);
    drive(1, 1, 3'b000, 5'd3, 5'd7, 5'd7, 1, 0, 0, 0);
    check_ctl("rs2_resolve", 2'b00, 0, 0, 0, 0);

    // Load to x0 never hazards; JAL never hazards
    drive(1, 1, 3'b000, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0);
    check_ctl("x0_load", 2'b01, 1, 0, 0, 0);
    drive(1, 2, 3'b000, 5'd4, 5'd4, 5'd4, 1, 0, 0, 0);
    check_ctl("jal_match", 2'b01, 1, 0, 0, 0);

    // JALR: plain, rs2 match (no hazard), rs1 match (hazard)
    drive(1, 3, 3'b000, 5'd1, 5'd2, 5'd9, 0, 0, 0, 0);
    check_ctl("jalr", 2'b10, 1, 0, 0, 0);
    drive(1, 3, 3'b000, 5'd1, 5'd8, 5'd8, 1, 0, 0, 0);
    check_ctl("jalr_rs2", 2'b10, 1, 0, 0, 0);
    drive(1, 3, 3'b000, 5'd8, 5'd2, 5'd8, 1, 0, 0, 0);
    check_ctl("jalr_stall", 2'b00, 0, 1, 1, 0);
    drive(1, 3, 3'b000, 5'd8, 5'd2, 5'd8, 1, 0, 0, 0);
    check_ctl("jalr_resolve", 2'b10, 1, 0, 0, 0);

    // Illegal funct3
    drive(1, 1, 3'b011, 5'd1, 5'd2, 5'd9, 0, 1, 1, 0);
    check_ctl("illegal011", 2'b00, 0, 0, 0, 1);
    drive(1, 1, 3'b010, 5'd1, 5'd2, 5'd9, 0, 0, 0, 0);
    check_ctl("illegal010", 2'b00, 0, 0, 0, 1);

    // Invalid slot ignored
    drive(0, 2, 3'b011, 5'd5, 5'd5, 5'd5, 1, 1, 1, 0);
    check_ctl("invalid", 2'b00, 0, 0, 0, 0);

    // Hold: taken branch suppressed; hazard keeps stall, no bubble, FSM frozen
    drive(1, 1, 3'b000, 5'd1, 5'd2, 5'd9, 0, 1, 0, 1);
    check_ctl("hold_beq", 2'b00, 0, 0, 0, 0);
    drive(1, 1, 3'b000, 5'd5, 5'd2, 5'd5, 1, 1, 0, 1);
    check_ctl("hold_haz", 2'b00, 0, 1, 0, 0);
    drive(1, 1, 3'b000, 5'd5, 5'd2, 5'd5, 1, 1, 0, 0);
    check_ctl("unhold_haz", 2'b00, 0, 1, 1, 0);
    drive(1, 1, 3'b000, 5'd5, 5'd2, 5'd5, 1, 1, 0, 0);
    check_ctl("unhold_res", 2'b01, 1, 0, 0, 0);

    // Reset in LDSTALL: abandon, return to RUN (hazard stalls again)
    drive(1, 1, 3'b001, 5'd5, 5'd6, 5'd5, 1, 0, 0, 0);
    check_ctl("pre_rst_stall", 2'b00, 0, 1, 1, 0);
    rst = 1'b1;
    #1;
    check_ctl("rst_in_ldstall", 2'b00, 0, 0, 0, 0);
    drive(1, 1, 3'b001, 5'd5, 5'd6, 5'd5, 1, 0, 0, 0);
    rst = 1'b0;
    #1;
    check_ctl("post_rst_run", 2'b00, 0, 1, 1, 0);
    check("post_rst.stat_taken",  {28'd0, stat_taken},  32'd0);
    check("post_rst.stat_stalls", {28'd0, stat_stalls}, 32'd0);

`ifdef BRANCH_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++)
      drive(1, 1, 3'b000, 5'd1, 5'd2, 5'd9, 0, 1, 0, 0);
    drive(0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    check("sat.stat_taken",    {28'd0, stat_taken},    32'd15);
    check("sat.stat_branches", {28'd0, stat_branches}, 32'd15);
    drive(0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    check("sat.held",          {28'd0, stat_taken},    32'd15);
    check("sat.stat_stalls",   {28'd0, stat_stalls},   32'd0);
`else
    check("nostats.stat_branches", {28'd0, stat_branches}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
